// File: rtl/axi_master_burst_engine.sv
// Single-outstanding AXI3 burst master: one command in, one INCR burst out, one completion pulse back.
// Commands that are misaligned or cross a 4 KB boundary are rejected without bus traffic.
module axi_master_burst_engine #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    aclk,
   input  logic                    areset,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [3:0]              cmd_len,
   input  logic [3:0]              cmd_id,
   input  logic                    wr_data_valid,
   output logic                    wr_data_ready,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   input  logic [DATA_WIDTH/8-1:0] wr_strb,
   output logic                    rd_data_valid,
   input  logic                    rd_data_ready,
   output logic [DATA_WIDTH-1:0]   rd_data,
   output logic                    rd_last,
   output logic                    done_valid,
   output logic [1:0]              done_resp,
   output logic [3:0]              done_id,
   output logic [3:0]              awid,
   output logic [ADDR_WIDTH-1:0]   awaddr,
   output logic [3:0]              awlen,
   output logic [2:0]              awsize,
   output logic [1:0]              awburst,
   output logic                    awvalid,
   input  logic                    awready,
   output logic [3:0]              wid,
   output logic [DATA_WIDTH-1:0]   wdata,
   output logic [DATA_WIDTH/8-1:0] wstrb,
   output logic                    wlast,
   output logic                    wvalid,
   input  logic                    wready,
   input  logic [3:0]              bid,
   input  logic [1:0]              bresp,
   input  logic                    bvalid,
   output logic                    bready,
   output logic [3:0]              arid,
   output logic [ADDR_WIDTH-1:0]   araddr,
   output logic [3:0]              arlen,
   output logic [2:0]              arsize,
   output logic [1:0]              arburst,
   output logic                    arvalid,
   input  logic                    arready,
   input  logic [3:0]              rid,
   input  logic [DATA_WIDTH-1:0]   rdata,
   input  logic [1:0]              rresp,
   input  logic                    rlast,
   input  logic                    rvalid,
   output logic                    rready
);

   typedef enum logic [2:0] {
      IDLE, CHECK, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE
   } state_t;

   state_t                  r_state;
   state_t                  w_next;
   logic                    r_write;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic [3:0]              r_len;
   logic [3:0]              r_id;
   logic [3:0]              r_cnt;
   logic [1:0]              r_resp;
   logic                    r_rderr;
   logic [12:0]             w_end;
   logic                    w_illegal;
   logic                    w_last_beat;
   logic                    w_w_hs;
   logic                    w_r_hs;

   // End offset of the burst within its 4 KB page; exactly 4096 is still legal.
   assign w_end       = {1'b0, r_addr[11:0]} + {7'd0, r_len, 2'b00} + 13'd4;
   assign w_illegal   = (r_addr[1:0] != 2'b00) || (w_end > 13'd4096);
   assign w_last_beat = (r_cnt == r_len);
   assign w_w_hs      = (r_state == WR_DATA) && wr_data_valid && wready;
   assign w_r_hs      = (r_state == RD_DATA) && rvalid && rd_data_ready;

   always_comb begin
      w_next        = r_state;
      cmd_ready     = 1'b0;
      awvalid       = 1'b0;
      awid          = '0;
      awaddr        = '0;
      awlen         = '0;
      awsize        = '0;
      awburst       = '0;
      arvalid       = 1'b0;
      arid          = '0;
      araddr        = '0;
      arlen         = '0;
      arsize        = '0;
      arburst       = '0;
      wvalid        = 1'b0;
      wr_data_ready = 1'b0;
      wdata         = '0;
      wstrb         = '0;
      wid           = '0;
      wlast         = 1'b0;
      bready        = 1'b0;
      rready        = 1'b0;
      rd_data_valid = 1'b0;
      rd_data       = '0;
      rd_last       = 1'b0;
      done_valid    = 1'b0;
      done_resp     = '0;
      done_id       = '0;
      case (r_state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) w_next = CHECK;
         end
         CHECK: begin
            if (w_illegal)    w_next = DONE;
            else if (r_write) w_next = WR_ADDR;
            else              w_next = RD_ADDR;
         end
         WR_ADDR: begin
            awvalid = 1'b1;
            awid    = r_id;
            awaddr  = r_addr;
            awlen   = r_len;
            awsize  = 3'b010;
            awburst = 2'b01;
            if (awready) w_next = WR_DATA;
         end
         WR_DATA: begin
            wvalid        = wr_data_valid;
            wr_data_ready = wready;
            wdata         = wr_data;
            wstrb         = wr_strb;
            wid           = r_id;
            wlast         = w_last_beat;
            if (w_w_hs && w_last_beat) w_next = WR_RESP;
         end
         WR_RESP: begin
            bready = 1'b1;
            if (bvalid) w_next = DONE;
         end
         RD_ADDR: begin
            arvalid = 1'b1;
            arid    = r_id;
            araddr  = r_addr;
            arlen   = r_len;
            arsize  = 3'b010;
            arburst = 2'b01;
            if (arready) w_next = RD_DATA;
         end
         RD_DATA: begin
            rd_data_valid = rvalid;
            rready        = rd_data_ready;
            rd_data       = rdata;
            rd_last       = w_last_beat;
            if (w_r_hs && w_last_beat) w_next = DONE;
         end
         DONE: begin
            done_valid = 1'b1;
            done_resp  = r_rderr ? 2'b10 : r_resp;
            done_id    = r_id;
            w_next     = IDLE;
         end
         default: w_next = IDLE;
      endcase
      // State already resets to IDLE; this only covers the cycle(s) before reset takes effect.
      if (areset) begin
         cmd_ready     = 1'b0;
         awvalid       = 1'b0;
         arvalid       = 1'b0;
         wvalid        = 1'b0;
         wr_data_ready = 1'b0;
         wlast         = 1'b0;
         bready        = 1'b0;
         rready        = 1'b0;
         rd_data_valid = 1'b0;
         rd_last       = 1'b0;
         done_valid    = 1'b0;
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         r_state <= IDLE;
         r_write <= 1'b0;
         r_addr  <= '0;
         r_len   <= '0;
         r_id    <= '0;
         r_cnt   <= '0;
         r_resp  <= '0;
         r_rderr <= 1'b0;
      end else begin
         r_state <= w_next;
         case (r_state)
            IDLE: if (cmd_valid) begin
               r_write <= cmd_write;
               r_addr  <= cmd_addr;
               r_len   <= cmd_len;
               r_id    <= cmd_id;
               r_cnt   <= '0;
               r_resp  <= '0;
               r_rderr <= 1'b0;
            end
            CHECK: if (w_illegal) r_resp <= 2'b10;
            WR_DATA: if (w_w_hs) r_cnt <= r_cnt + 4'd1;
            WR_RESP: if (bvalid) r_resp <= (bid != r_id) ? 2'b10 : bresp;
            RD_DATA: if (w_r_hs) begin
               r_cnt <= r_cnt + 4'd1;
               if (rresp > r_resp) r_resp <= rresp;
               if ((rid != r_id) || (rlast != w_last_beat)) r_rderr <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_master_burst_engine.sv
// Directed bench for axi_master_burst_engine: a small in-bench AXI slave drives each
// burst and every observed value is compared against hand-set expectations.
module tb_axi_master_burst_engine;

   logic        aclk = 1'b0;
   logic        areset;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr;
   logic [3:0]  cmd_len, cmd_id;
   logic        wr_data_valid, wr_data_ready;
   logic [31:0] wr_data;
   logic [3:0]  wr_strb;
   logic        rd_data_valid, rd_data_ready, rd_last;
   logic [31:0] rd_data;
   logic        done_valid;
   logic [1:0]  done_resp;
   logic [3:0]  done_id;
   logic [3:0]  awid, awlen;
   logic [31:0] awaddr;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic        awvalid, awready;
   logic [3:0]  wid;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast, wvalid, wready;
   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid, bready;
   logic [3:0]  arid, arlen;
   logic [31:0] araddr;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid, arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast, rvalid, rready;

   int total = 0;
   int bad   = 0;

   logic [31:0] wbeats [16];
   logic [31:0] rbeats [16];
   logic [3:0]  rids   [16];
   logic [1:0]  rresps [16];
   logic        rlasts [16];

   always #5 aclk = ~aclk;

   axi_master_burst_engine #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .aclk(aclk), .areset(areset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
      .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready),
      .wr_data(wr_data), .wr_strb(wr_strb),
      .rd_data_valid(rd_data_valid), .rd_data_ready(rd_data_ready),
      .rd_data(rd_data), .rd_last(rd_last),
      .done_valid(done_valid), .done_resp(done_resp), .done_id(done_id),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
      .awburst(awburst), .awvalid(awvalid), .awready(awready),
      .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
      .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
      .arburst(arburst), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
      .rvalid(rvalid), .rready(rready)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic fill(input logic [7:0] seed, input logic [3:0] id, input logic [3:0] len);
      for (int i = 0; i < 16; i++) begin
         wbeats[i] = {seed, 8'hA5, 8'(i), 8'(i * 3)};
         rbeats[i] = {8'h5A, seed, 8'(i * 7), 8'(i)};
         rids[i]   = id;
         rresps[i] = 2'b00;
         rlasts[i] = (i == int'(len));
      end
   endtask

   // Issues one command and plays the slave until done_valid, or until the
   // write beat abort_beat is reached, at which point areset is raised and control returns.
   task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [3:0] len,
                          input logic [3:0] id, input bit stall, input int axdelay,
                          input logic [1:0] b_resp, input logic [3:0] b_id,
                          input logic [1:0] exp_resp, input bit legal, input int abort_beat);
      int c = 1;
      int axc = 0;
      int widx = 0;
      int ridx = 0;
      bit seen_done = 0;
      logic [44:0] ax0 = '0;
      logic [44:0] axn;
      chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_len   = len;
      cmd_id    = id;
      tick();
      cmd_addr  = 32'hDEAD_BEEF;
      cmd_len   = ~len;
      cmd_id    = ~id;
      cmd_write = ~wr;
      while (c < 200) begin
         cmd_valid     = 1'b1;
         awready       = wr && (axc >= axdelay);
         arready       = !wr && (axc >= axdelay);
         wready        = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         wr_data_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         wr_data       = wbeats[widx % 16];
         wr_strb       = 4'(widx);
         bvalid        = 1'b1;
         bid           = b_id;
         bresp         = b_resp;
         rvalid        = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         rd_data_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         rdata         = rbeats[ridx % 16];
         rid           = rids[ridx % 16];
         rresp         = rresps[ridx % 16];
         rlast         = rlasts[ridx % 16];
         if (abort_beat >= 0 && widx == abort_beat) begin
            areset    = 1'b1;
            cmd_valid = 1'b0;
            chk("abort_no_done", 64'(seen_done), 64'd0);
            return;
         end
         #1;
         if (awvalid || arvalid) begin
            axn = awvalid ? {awid, awaddr, awlen, awsize, awburst}
                          : {arid, araddr, arlen, arsize, arburst};
            if (axc == 0) begin
               ax0 = axn;
               chk("ax_latency", 64'(c), 64'd2);
               chk("ax_dir", 64'(awvalid), 64'(wr));
               chk("ax_payload", 64'(axn), 64'({id, addr, len, 3'b010, 2'b01}));
            end else begin
               chk("ax_stable", 64'(axn), 64'(ax0));
            end
            axc++;
         end
         if (wvalid && wready) begin
            chk("wdata", 64'(wdata), 64'(wbeats[widx % 16]));
            chk("wstrb", 64'(wstrb), 64'(4'(widx)));
            chk("wid", 64'(wid), 64'(id));
            chk("wlast", 64'(wlast), 64'(widx == int'(len)));
            widx++;
         end
         if (rd_data_valid && rd_data_ready) begin
            chk("rd_data", 64'(rd_data), 64'(rbeats[ridx % 16]));
            chk("rd_last", 64'(rd_last), 64'(ridx == int'(len)));
            ridx++;
         end
         if (done_valid) begin
            chk("done_resp", 64'(done_resp), 64'(exp_resp));
            chk("done_id", 64'(done_id), 64'(id));
            if (!legal) chk("reject_latency", 64'(c), 64'd2);
            seen_done = 1;
            break;
         end
         @(posedge aclk);
         #1;
         c++;
      end
      chk("done_seen", 64'(seen_done), 64'd1);
      if (legal) begin
         chk("ax_cycles", 64'(axc), 64'(axdelay + 1));
         chk("wr_beats", 64'(widx), wr ? 64'(len) + 64'd1 : 64'd0);
         chk("rd_beats", 64'(ridx), wr ? 64'd0 : 64'(len) + 64'd1);
      end else begin
         chk("reject_no_ax", 64'(axc), 64'd0);
      end
      cmd_valid = 1'b0;
      bvalid    = 1'b0;
      rvalid    = 1'b0;
      tick();
      chk("done_one_cycle", 64'(done_valid), 64'd0);
      chk("back_to_idle", 64'(cmd_ready), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      areset = 1'b1;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_id = '0;
      wr_data_valid = 1'b0; wr_data = '0; wr_strb = '0; rd_data_ready = 1'b0;
      awready = 1'b0; wready = 1'b0; arready = 1'b0;
      bid = '0; bresp = '0; bvalid = 1'b0;
      rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
      tick();
      tick();
      chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
      chk("rst_valids", 64'({awvalid, arvalid, wvalid, bready, rready, wr_data_ready,
                             rd_data_valid, done_valid}), 64'd0);
      chk("rst_payload", 64'({awaddr, araddr, wdata}), 64'd0);
      areset = 1'b0;
      tick();
      chk("post_rst_ready", 64'(cmd_ready), 64'd1);

      // write 0x100, len 3, id 5, no stalls
      fill(8'h01, 4'd5, 4'd3);
      run_txn(1'b1, 32'h100, 4'd3, 4'd5, 0, 0, 2'b00, 4'd5, 2'b00, 1, -1);

      // read 0x0, len 0, rresp OKAY-exclusive, arready after 3 cycles
      fill(8'h02, 4'd9, 4'd0);
      rresps[0] = 2'b01;
      run_txn(1'b0, 32'h0, 4'd0, 4'd9, 0, 3, 2'b00, 4'd0, 2'b01, 1, -1);

      // 4 KB crossing and misaligned writes rejected
      fill(8'h03, 4'd1, 4'd2);
      run_txn(1'b1, 32'hFF8, 4'd2, 4'd1, 0, 0, 2'b00, 4'd1, 2'b10, 0, -1);
      run_txn(1'b1, 32'h102, 4'd2, 4'd1, 0, 0, 2'b00, 4'd1, 2'b10, 0, -1);

      // read ending exactly on the 4 KB boundary, with stalls
      fill(8'h04, 4'd7, 4'd3);
      rresps[1] = 2'b01;
      run_txn(1'b0, 32'h1FF0, 4'd3, 4'd7, 1, 1, 2'b00, 4'd0, 2'b01, 1, -1);

      // read crossing 4 KB rejected
      fill(8'h05, 4'd2, 4'd15);
      run_txn(1'b0, 32'hFC4, 4'd15, 4'd2, 0, 0, 2'b00, 4'd0, 2'b10, 0, -1);

      // read len 3: early rlast on beat 2, rid mismatch on beat 1
      fill(8'h06, 4'd4, 4'd3);
      rids[0]   = 4'd8;
      rlasts[1] = 1'b1;
      rlasts[3] = 1'b0;
      run_txn(1'b0, 32'h300, 4'd3, 4'd4, 0, 0, 2'b00, 4'd0, 2'b10, 1, -1);

      // stalled write, bresp passed through
      fill(8'h07, 4'hA, 4'd7);
      run_txn(1'b1, 32'h40, 4'd7, 4'hA, 1, 2, 2'b01, 4'hA, 2'b01, 1, -1);

      // stalled 16-beat read, worst rresp wins
      fill(8'h08, 4'd3, 4'd15);
      rresps[4] = 2'b01;
      rresps[9] = 2'b11;
      rresps[12] = 2'b10;
      run_txn(1'b0, 32'h0, 4'd15, 4'd3, 1, 0, 2'b00, 4'd0, 2'b11, 1, -1);

      // write with bid mismatch
      fill(8'h09, 4'd6, 4'd1);
      run_txn(1'b1, 32'h80, 4'd1, 4'd6, 0, 0, 2'b00, 4'd4, 2'b10, 1, -1);

      // reset during write beat 2, then a fresh command
      fill(8'h0A, 4'd2, 4'd3);
      run_txn(1'b1, 32'h200, 4'd3, 4'd2, 0, 0, 2'b00, 4'd2, 2'b00, 1, 2);
      tick();
      chk("abort_valids", 64'({awvalid, arvalid, wvalid, bready, rready, wr_data_ready,
                               rd_data_valid, done_valid, cmd_ready}), 64'd0);
      areset = 1'b0;
      wr_data_valid = 1'b0;
      bvalid = 1'b0;
      rvalid = 1'b0;
      tick();
      chk("abort_release_ready", 64'(cmd_ready), 64'd1);
      chk("abort_release_done", 64'(done_valid), 64'd0);
      fill(8'h0B, 4'd2, 4'd2);
      run_txn(1'b1, 32'h200, 4'd2, 4'd2, 0, 0, 2'b00, 4'd2, 2'b00, 1, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
